// File: rtl/oht2bin_pkg.sv
// rtl/oht2bin_pkg.sv - shared types and encode helpers for the one-hot to binary pipeline
//
// Purpose: encode helpers and the stage-2 payload type.
// Vectors are handled at MAX_W bits so one function serves every WIDTH.
// Callers zero-extend their vector and use the low index bits of the result.
package oht2bin_pkg;

    localparam int MAX_W   = 256;
    localparam int MAX_LOG = $clog2(MAX_W);

    typedef struct packed {
        logic [MAX_LOG-1:0] bin;
        logic               zero;
        logic               err;
    } s2_payload_t;

    // OR of the indices of all set bits: exact for one-hot, harmless otherwise.
    function automatic logic [MAX_LOG-1:0] oht2bin(input logic [MAX_W-1:0] vec);
        logic [MAX_LOG-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (vec[i]) begin
                bin = bin | MAX_LOG'(i);
            end
        end
        return bin;
    endfunction

    // Clearing the lowest set bit leaves something only if more than one bit was set.
    function automatic logic is_multihot(input logic [MAX_W-1:0] vec);
        return |(vec & (vec - MAX_W'(1)));
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/ready register slice
//
// Purpose: a single full-throughput register slice.
// Ready is combinational from downstream ready.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   up_vld, up_rdy, up_data   upstream handshake and payload
//   dn_vld, dn_rdy, dn_data   downstream handshake and registered payload
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [W-1:0] up_data,
    output logic         dn_vld,
    input  logic         dn_rdy,
    output logic [W-1:0] dn_data
);

    // Empty, or being drained this cycle, so a new word can land.
    assign up_rdy = ~dn_vld | dn_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_vld  <= 1'b0;
            dn_data <= '0;
        end else if (up_vld && up_rdy) begin
            dn_vld  <= 1'b1;
            dn_data <= up_data;
        end else if (dn_rdy) begin
            dn_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/oht2bin_pipe.sv
// rtl/oht2bin_pipe.sv - two-stage pipelined one-hot to binary encoder
//
// Purpose: encode a one-hot grant vector into its binary index.
// Stage 1 registers the raw vector; stage 2 registers the encoded result.
// Optional macro OHT2BIN_PIPE_ERR_EN adds multi-hot detection and a saturating count.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_vld, i_rdy, i_oht       input handshake and one-hot (or zero) vector
//   o_vld, o_rdy              output handshake
//   o_bin, o_zero             binary index, all-zero flag
//   o_err, o_err_cnt          multi-hot flag and saturating count (0 without macro)
module oht2bin_pipe
    import oht2bin_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int CNT_W     = 8,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [WIDTH-1:0]     i_oht,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [WIDTH_LOG-1:0] o_bin,
    output logic                 o_zero,
    output logic                 o_err,
    output logic [CNT_W-1:0]     o_err_cnt
);

    logic             s1_vld;
    logic             s2_rdy;
    logic [WIDTH-1:0] s1_data;
    logic [MAX_W-1:0] s1_ext;
    s2_payload_t      s2_d;
    s2_payload_t      s2_q;

    pipe_stage #(.W(WIDTH)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .up_vld  (i_vld),
        .up_rdy  (i_rdy),
        .up_data (i_oht),
        .dn_vld  (s1_vld),
        .dn_rdy  (s2_rdy),
        .dn_data (s1_data)
    );

    always_comb begin
        s1_ext            = '0;
        s1_ext[WIDTH-1:0] = s1_data;
        s2_d.bin          = oht2bin(s1_ext);
        s2_d.zero         = ~|s1_data;
`ifdef OHT2BIN_PIPE_ERR_EN
        s2_d.err          = is_multihot(s1_ext);
`else
        s2_d.err          = 1'b0;
`endif
    end

    pipe_stage #(.W($bits(s2_payload_t))) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .up_vld  (s1_vld),
        .up_rdy  (s2_rdy),
        .up_data (s2_d),
        .dn_vld  (o_vld),
        .dn_rdy  (o_rdy),
        .dn_data (s2_q)
    );

    assign o_bin  = s2_q.bin[WIDTH_LOG-1:0];
    assign o_zero = s2_q.zero;

    // Index bits above WIDTH_LOG are always zero because the vector was zero-extended.
    generate
        if (WIDTH_LOG < MAX_LOG) begin : g_bin_hi
            logic unused_bin_hi;
            assign unused_bin_hi = ^s2_q.bin[MAX_LOG-1:WIDTH_LOG];
        end
    endgenerate

`ifdef OHT2BIN_PIPE_ERR_EN
    logic [CNT_W-1:0] err_cnt;

    // Counted on the output transfer, so a stalled word is counted once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (o_vld && o_rdy && s2_q.err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign o_err     = s2_q.err;
    assign o_err_cnt = err_cnt;
`else
    logic unused_err;
    assign unused_err = s2_q.err;
    assign o_err      = 1'b0;
    assign o_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_oht2bin_pipe.sv
// tb/tb_oht2bin_pipe.sv - directed self-checking bench for oht2bin_pipe
module tb_oht2bin_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vld;
    logic        i_rdy;
    logic [31:0] i_oht;
    logic        o_vld;
    logic        o_rdy;
    logic [4:0]  o_bin;
    logic        o_zero;
    logic        o_err;
    logic [7:0]  o_err_cnt;

    int passes = 0;
    int total  = 0;

    oht2bin_pipe #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (i_vld),
        .i_rdy     (i_rdy),
        .i_oht     (i_oht),
        .o_vld     (o_vld),
        .o_rdy     (o_rdy),
        .o_bin     (o_bin),
        .o_zero    (o_zero),
        .o_err     (o_err),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [31:0] bp_data [4];
        int          idx;
        int          accepted;

        bp_data[0] = 32'h0000_0008;
        bp_data[1] = 32'h0000_0080;
        bp_data[2] = 32'h0000_1000;
        bp_data[3] = 32'h0010_0000;

        rst   = 1'b1;
        i_vld = 1'b1;
        i_oht = 32'h0000_0001;
        o_rdy = 1'b1;
        #1;
        chk("rst_o_vld", 32'(o_vld), 32'd0);
        chk("rst_o_bin", 32'(o_bin), 32'd0);
        chk("rst_o_zero", 32'(o_zero), 32'd0);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_o_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("rst_i_rdy", 32'(i_rdy), 32'd1);
        repeat (2) @(negedge clk);
        chk("rst_ignores_input", 32'(o_vld), 32'd0);
        i_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_o_vld", 32'(o_vld), 32'd0);

        // single transfer
        i_vld = 1'b1;
        i_oht = 32'h0000_0100;
        #1;
        chk("single_i_rdy", 32'(i_rdy), 32'd1);
        @(negedge clk);
        i_vld = 1'b0;
        chk("single_lat1_o_vld", 32'(o_vld), 32'd0);
        @(negedge clk);
        chk("single_o_vld", 32'(o_vld), 32'd1);
        chk("single_o_bin", 32'(o_bin), 32'd8);
        chk("single_o_zero", 32'(o_zero), 32'd0);
        chk("single_o_err", 32'(o_err), 32'd0);
        @(negedge clk);
        chk("single_drained", 32'(o_vld), 32'd0);

        // streaming 1<<0 .. 1<<31
        for (int n = 0; n < 34; n++) begin
            if (n >= 2) begin
                chk("stream_o_vld", 32'(o_vld), 32'd1);
                chk("stream_o_bin", 32'(o_bin), 32'(n - 2));
            end
            if (n < 32) begin
                i_vld = 1'b1;
                i_oht = 32'd1 << n;
                #1;
                chk("stream_i_rdy", 32'(i_rdy), 32'd1);
            end else begin
                i_vld = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_drained", 32'(o_vld), 32'd0);

        // backpressure: o_rdy low for 5 cycles, 4 inputs offered
        o_rdy    = 1'b0;
        idx      = 0;
        accepted = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 4) begin
                i_vld = 1'b1;
                i_oht = bp_data[idx];
            end else begin
                i_vld = 1'b0;
            end
            #1;
            if (i_vld && i_rdy) begin
                idx++;
                accepted++;
            end
            @(negedge clk);
        end
        chk("bp_accepted", 32'(accepted), 32'd2);
        #1;
        chk("bp_i_rdy_low", 32'(i_rdy), 32'd0);
        chk("bp_stall_o_vld", 32'(o_vld), 32'd1);
        chk("bp_stall_o_bin", 32'(o_bin), 32'd3);
        i_vld = 1'b0;
        o_rdy = 1'b1;
        @(negedge clk);
        chk("bp_out2_o_vld", 32'(o_vld), 32'd1);
        chk("bp_out2_o_bin", 32'(o_bin), 32'd7);
        @(negedge clk);
        chk("bp_no_dup", 32'(o_vld), 32'd0);

        // zero input
        i_vld = 1'b1;
        i_oht = 32'h0;
        @(negedge clk);
        i_vld = 1'b0;
        @(negedge clk);
        chk("zero_o_vld", 32'(o_vld), 32'd1);
        chk("zero_o_bin", 32'(o_bin), 32'd0);
        chk("zero_o_zero", 32'(o_zero), 32'd1);
        chk("zero_o_err", 32'(o_err), 32'd0);
        @(negedge clk);

        // multi-hot 0x5
        i_vld = 1'b1;
        i_oht = 32'h0000_0005;
        @(negedge clk);
        i_vld = 1'b0;
        chk("mh_cnt_before", 32'(o_err_cnt), 32'd0);
        @(negedge clk);
        chk("mh_o_vld", 32'(o_vld), 32'd1);
        chk("mh_o_bin", 32'(o_bin), 32'd2);
        chk("mh_o_zero", 32'(o_zero), 32'd0);
`ifdef OHT2BIN_PIPE_ERR_EN
        chk("mh_o_err", 32'(o_err), 32'd1);
        chk("mh_cnt_at_out", 32'(o_err_cnt), 32'd0);
        @(negedge clk);
        chk("mh_cnt_one", 32'(o_err_cnt), 32'd1);
        i_vld = 1'b1;
        i_oht = 32'h0000_0005;
        repeat (299) @(negedge clk);
        i_vld = 1'b0;
        repeat (4) @(negedge clk);
        chk("mh_cnt_saturated", 32'(o_err_cnt), 32'd255);
`else
        chk("mh_o_err_off", 32'(o_err), 32'd0);
        @(negedge clk);
        chk("mh_cnt_off", 32'(o_err_cnt), 32'd0);
`endif

        // reset mid-stream with both stages full
        o_rdy = 1'b0;
        i_vld = 1'b1;
        i_oht = 32'h0000_0010;
        @(negedge clk);
        i_oht = 32'h0000_0020;
        @(negedge clk);
        i_vld = 1'b0;
        #1;
        chk("mid_full_o_vld", 32'(o_vld), 32'd1);
        chk("mid_full_i_rdy", 32'(i_rdy), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_o_vld", 32'(o_vld), 32'd0);
        chk("mid_rst_o_bin", 32'(o_bin), 32'd0);
        chk("mid_rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("mid_rst_cnt", 32'(o_err_cnt), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        o_rdy = 1'b1;
        @(negedge clk);
        chk("after_rst_o_vld", 32'(o_vld), 32'd0);
        chk("after_rst_i_rdy", 32'(i_rdy), 32'd1);
        @(negedge clk);
        chk("after_rst_empty", 32'(o_vld), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
